// File: rtl/luma_key_pkg.sv
// Shared widths, reset constants and divider state encoding for the luma keyer.
// Types and helpers only; no logic of its own.
package luma_key_pkg;
  localparam int SUM_W = 32;
  localparam int CNT_W = 22;
  localparam logic [7:0] MEAN_RST = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Clamp mean + signed offset into 0..255.
  function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [7:0] off);
    logic signed [9:0] s;
    s = $signed({2'b00, base}) + $signed({{2{off[7]}}, off});
    if (s[9])      return 8'h00;
    else if (s[8]) return 8'hFF;
    else           return s[7:0];
  endfunction
endpackage

// File: rtl/luma_mean_div.sv
// Frame-mean engine: snapshots sum/count and runs an 8-step restoring divide.
// Result 9 cycles after the snapshot; never stalls, a new snapshot aborts a busy divide.
module luma_mean_div
  import luma_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             snap,
  input  logic [SUM_W-1:0] sum_in,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [7:0]       mean_out,
  output logic             mean_valid
);
  div_state_e       state_q, state_d;
  logic [SUM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [7:0]       quo_q, quo_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       mean_q, mean_d;
  logic             vld_q, vld_d;
  logic [SUM_W-1:0] trial;
  logic             fits;
  logic [7:0]       quo_nxt;

  always_comb begin
    trial   = SUM_W'(div_q) << bit_q;
    fits    = (rem_q >= trial);
    quo_nxt = quo_q | (fits ? (8'd1 << bit_q) : 8'd0);
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    bit_d   = bit_q;
    mean_d  = mean_q;
    vld_d   = 1'b0;
    case (state_q)
      ST_DIV: begin
        if (fits) rem_d = rem_q - trial;
        quo_d = quo_nxt;
        if (bit_q == 3'd0) begin
          state_d = ST_DONE;
          mean_d  = quo_nxt;
          vld_d   = 1'b1;
        end else begin
          bit_d = bit_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh snapshot always wins, even on the last iteration.
    if (snap) begin
      rem_d   = sum_in;
      div_d   = cnt_in;
      quo_d   = 8'h00;
      bit_d   = 3'd7;
      mean_d  = mean_q;
      vld_d   = 1'b0;
      state_d = (cnt_in != '0) ? ST_DIV : ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      bit_q   <= '0;
      mean_q  <= MEAN_RST;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      bit_q   <= bit_d;
      mean_q  <= mean_d;
      vld_q   <= vld_d;
    end
  end

  assign mean_out   = mean_q;
  assign mean_valid = vld_q;
endmodule

// File: rtl/luma_key.sv
// Luma keyer: hard 0x00/0xFF mask with line-local hysteresis, manual or mean-derived threshold.
// Pixel latency 2 cycles, one pixel per clock, no backpressure.
module luma_key
  import luma_key_pkg::*;
#(
  parameter logic SYNC_POL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] vid_pData_in,
  input  logic       vid_pVDE_in,
  input  logic       vid_pHSync_in,
  input  logic       vid_pVSync_in,
  input  logic       auto_en,
  input  logic [7:0] thresh_in,
  input  logic [7:0] offset_in,
  input  logic [3:0] hyst_in,
  input  logic       invert,
  output logic [7:0] vid_pData_out,
  output logic       vid_pVDE_out,
  output logic       vid_pHSync_out,
  output logic       vid_pVSync_out,
  output logic [7:0] mean_out,
  output logic       mean_valid
);
  logic [7:0]       luma_s1_q, luma_s1_d;
  logic             de_s1_q, de_s1_d, hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
  logic             fedge_s1_q, fedge_s1_d, derise_s1_q, derise_s1_d;
  logic [7:0]       dat_s2_q, dat_s2_d;
  logic             de_s2_q, de_s2_d, hs_s2_q, hs_s2_d, vs_s2_q, vs_s2_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       thr_q, thr_d;
  logic             arm_q, arm_d, kst_q, kst_d;
  logic             armed, latch, key;
  logic [7:0]       thr_eff, thr_lo;

  always_comb begin
    luma_s1_d   = vid_pData_in;
    de_s1_d     = vid_pVDE_in;
    hs_s1_d     = vid_pHSync_in;
    vs_s1_d     = vid_pVSync_in;
    fedge_s1_d  = (vid_pVSync_in == SYNC_POL) && (vs_s1_q != SYNC_POL);
    derise_s1_d = vid_pVDE_in && !de_s1_q;

    // The pixel sharing the edge cycle opens the new frame.
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (fedge_s1_q) begin
      sum_d = de_s1_q ? SUM_W'(luma_s1_q) : '0;
      cnt_d = de_s1_q ? CNT_W'(1) : '0;
    end else if (de_s1_q) begin
      sum_d = sum_q + SUM_W'(luma_s1_q);
      cnt_d = cnt_q + CNT_W'(1);
    end

    // The latching pixel already uses the new threshold, so thr is frame-constant.
    armed   = arm_q | fedge_s1_q;
    latch   = armed & derise_s1_q;
    thr_eff = thr_q;
    if (latch) thr_eff = auto_en ? sat_add(mean_out, offset_in) : thresh_in;
    thr_d = thr_eff;
    arm_d = armed & ~latch;

    thr_lo   = (thr_eff > {4'b0000, hyst_in}) ? (thr_eff - {4'b0000, hyst_in}) : 8'h00;
    key      = kst_q ? (luma_s1_q >= thr_lo) : (luma_s1_q >= thr_eff);
    kst_d    = de_s1_q & key;
    dat_s2_d = (de_s1_q && (key ^ invert)) ? 8'hFF : 8'h00;
    de_s2_d  = de_s1_q;
    hs_s2_d  = hs_s1_q;
    vs_s2_d  = vs_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      luma_s1_q   <= '0;
      de_s1_q     <= 1'b0;
      hs_s1_q     <= 1'b0;
      vs_s1_q     <= 1'b0;
      fedge_s1_q  <= 1'b0;
      derise_s1_q <= 1'b0;
      dat_s2_q    <= '0;
      de_s2_q     <= 1'b0;
      hs_s2_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      sum_q       <= '0;
      cnt_q       <= '0;
      thr_q       <= MEAN_RST;
      arm_q       <= 1'b0;
      kst_q       <= 1'b0;
    end else begin
      luma_s1_q   <= luma_s1_d;
      de_s1_q     <= de_s1_d;
      hs_s1_q     <= hs_s1_d;
      vs_s1_q     <= vs_s1_d;
      fedge_s1_q  <= fedge_s1_d;
      derise_s1_q <= derise_s1_d;
      dat_s2_q    <= dat_s2_d;
      de_s2_q     <= de_s2_d;
      hs_s2_q     <= hs_s2_d;
      vs_s2_q     <= vs_s2_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      thr_q       <= thr_d;
      arm_q       <= arm_d;
      kst_q       <= kst_d;
    end
  end

  luma_mean_div u_div (
    .clk        (clk),
    .rst        (rst),
    .snap       (fedge_s1_q),
    .sum_in     (sum_q),
    .cnt_in     (cnt_q),
    .mean_out   (mean_out),
    .mean_valid (mean_valid)
  );

  assign vid_pData_out  = dat_s2_q;
  assign vid_pVDE_out   = de_s2_q;
  assign vid_pHSync_out = hs_s2_q;
  assign vid_pVSync_out = vs_s2_q;
endmodule

// File: tb/tb_luma_key.sv
// Randomised + directed bench for luma_key against a frame-level reference model.
`timescale 1ns/1ps
module tb_luma_key;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] vid_pData_in = '0;
  logic       vid_pVDE_in = 1'b0, vid_pHSync_in = 1'b0, vid_pVSync_in = 1'b0;
  logic       auto_en = 1'b0;
  logic [7:0] thresh_in = 8'd100, offset_in = 8'd0;
  logic [3:0] hyst_in = 4'd0;
  logic       invert = 1'b0;
  logic [7:0] vid_pData_out, mean_out;
  logic       vid_pVDE_out, vid_pHSync_out, vid_pVSync_out, mean_valid;

  luma_key #(.SYNC_POL(1'b1)) dut (
    .clk(clk), .rst(rst),
    .vid_pData_in(vid_pData_in), .vid_pVDE_in(vid_pVDE_in),
    .vid_pHSync_in(vid_pHSync_in), .vid_pVSync_in(vid_pVSync_in),
    .auto_en(auto_en), .thresh_in(thresh_in), .offset_in(offset_in),
    .hyst_in(hyst_in), .invert(invert),
    .vid_pData_out(vid_pData_out), .vid_pVDE_out(vid_pVDE_out),
    .vid_pHSync_out(vid_pHSync_out), .vid_pVSync_out(vid_pVSync_out),
    .mean_out(mean_out), .mean_valid(mean_valid)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  logic       c_auto = 1'b0, c_inv = 1'b0;
  logic [7:0] c_thr = 8'd100, c_off = 8'd0;
  logic [3:0] c_hyst = 4'd0;

  typedef struct {int at; int kind; logic [7:0] val; string nm;} lit_t;
  lit_t lits[$];

  typedef struct packed {logic de; logic hs; logic vs; logic [7:0] luma;} pix_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic lit(input int at, input int kind, input logic [7:0] val, input string nm);
    lit_t e;
    e.at = at; e.kind = kind; e.val = val; e.nm = nm;
    lits.push_back(e);
  endtask

  task automatic step(input logic r, input logic de, input logic hs, input logic vs, input logic [7:0] l);
    @(posedge clk); #1;
    rst = r; vid_pVDE_in = de; vid_pHSync_in = hs; vid_pVSync_in = vs; vid_pData_in = l;
    auto_en = c_auto; thresh_in = c_thr; offset_in = c_off; hyst_in = c_hyst; invert = c_inv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, (i < 2), 1'b0, 8'($urandom));
  endtask

  task automatic vsync(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
  endtask

  task automatic pix(input logic [7:0] l, input int kind_exp, input logic [7:0] e, input string nm);
    step(1'b0, 1'b1, 1'b0, 1'b0, l);
    if (kind_exp >= 0) lit(cyc + 2, 0, e, nm);
  endtask

  // Reference model state
  bit         chk_on = 0;
  pix_t       m_p, m_prev;
  longint     m_sum;
  int         m_cnt, m_mean, m_thr, m_pend_val, m_pend_at;
  bit         m_pend, m_armed, m_kst;
  logic [7:0] e_dat [4];
  logic       e_de [4], e_hs [4], e_vs [4];

  always @(negedge clk) begin
    int ix, t, lo;
    bit vfire, k;
    vfire = 0;
    if (m_pend && m_pend_at == cyc) begin
      m_mean = m_pend_val; m_pend = 0; vfire = 1;
    end
    if (chk_on) begin
      ix = cyc % 4;
      chk("data_out", 32'(vid_pData_out), 32'(e_dat[ix]));
      chk("de_out", 32'(vid_pVDE_out), 32'(e_de[ix]));
      chk("hs_out", 32'(vid_pHSync_out), 32'(e_hs[ix]));
      chk("vs_out", 32'(vid_pVSync_out), 32'(e_vs[ix]));
      chk("mean_out", 32'(mean_out), 32'(m_mean));
      chk("mean_valid", 32'(mean_valid), 32'(vfire));
    end
    for (int i = lits.size() - 1; i >= 0; i--) begin
      if (lits[i].at == cyc) begin
        case (lits[i].kind)
          0: chk(lits[i].nm, 32'(vid_pData_out), 32'(lits[i].val));
          1: chk(lits[i].nm, 32'(mean_out), 32'(lits[i].val));
          2: chk(lits[i].nm, 32'(mean_valid), 32'(lits[i].val));
          default: chk(lits[i].nm, 32'(vid_pVDE_out), 32'(lits[i].val));
        endcase
        lits.delete(i);
      end
    end
    ix = (cyc + 1) % 4;
    if (rst) begin
      e_dat[ix] = 8'h00; e_de[ix] = 0; e_hs[ix] = 0; e_vs[ix] = 0;
      m_sum = 0; m_cnt = 0; m_pend = 0; m_mean = 128; m_thr = 128;
      m_armed = 0; m_kst = 0; m_p = '0; m_prev = '0;
      chk_on = 1;
    end else if (chk_on) begin
      if (m_p.vs && !m_prev.vs) begin
        if (m_cnt != 0) begin
          m_pend = 1; m_pend_val = int'(m_sum / m_cnt); m_pend_at = cyc + 9;
        end else m_pend = 0;
        m_sum = 0; m_cnt = 0; m_armed = 1;
      end
      if (m_p.de) begin m_sum += m_p.luma; m_cnt++; end
      if (m_armed && m_p.de && !m_prev.de) begin
        if (auto_en) begin
          t = m_mean + int'($signed(offset_in));
          if (t < 0) t = 0;
          if (t > 255) t = 255;
        end else t = int'(thresh_in);
        m_thr = t; m_armed = 0;
      end
      lo = m_thr - int'(hyst_in);
      if (lo < 0) lo = 0;
      if (m_p.de) begin
        k = m_kst ? (int'(m_p.luma) >= lo) : (int'(m_p.luma) >= m_thr);
        m_kst = k;
        e_dat[ix] = (k ^ invert) ? 8'hFF : 8'h00;
      end else begin
        m_kst = 0;
        e_dat[ix] = 8'h00;
      end
      e_de[ix] = m_p.de; e_hs[ix] = m_p.hs; e_vs[ix] = m_p.vs;
      m_prev = m_p;
      m_p.de = vid_pVDE_in; m_p.hs = vid_pHSync_in; m_p.vs = vid_pVSync_in; m_p.luma = vid_pData_in;
    end
  end

  initial begin
    int t0, v, nl, len;
    // Reset while the video inputs toggle
    for (int i = 0; i < 3; i++) step(1'b1, (i != 1), (i % 2 == 1), 1'b1, 8'($urandom));
    lit(cyc + 1, 1, 8'h80, "rst_mean");
    lit(cyc + 1, 0, 8'h00, "rst_data");
    lit(cyc + 1, 2, 8'h00, "rst_valid");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd200);
    lit(cyc + 2, 3, 8'h01, "de_follows");
    idle(3);
    vsync(2); idle(5);

    // Manual threshold 100, no hysteresis
    pix(8'd98, 0, 8'h00, "man_98"); pix(8'd99, 0, 8'h00, "man_99");
    pix(8'd100, 0, 8'hFF, "man_100"); pix(8'd101, 0, 8'hFF, "man_101");
    idle(3);
    c_inv = 1; idle(2);
    pix(8'd98, 0, 8'hFF, "inv_98"); pix(8'd99, 0, 8'hFF, "inv_99");
    pix(8'd100, 0, 8'h00, "inv_100"); pix(8'd101, 0, 8'h00, "inv_101");
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd200);
    lit(cyc + 2, 0, 8'h00, "inv_de0");
    idle(3); c_inv = 0;

    // Hysteresis width 8
    c_hyst = 4'd8; idle(2);
    pix(8'd105, 0, 8'hFF, "hy_105"); pix(8'd95, 0, 8'hFF, "hy_95a");
    pix(8'd92, 0, 8'hFF, "hy_92"); pix(8'd91, 0, 8'h00, "hy_91");
    pix(8'd95, 0, 8'h00, "hy_95b"); pix(8'd105, 0, 8'hFF, "hy_105b");
    idle(2);
    pix(8'd95, 0, 8'h00, "hy_newline");
    idle(3); c_hyst = 4'd0;

    // Auto mean: 1000 pixels at 60
    vsync(2); idle(12);
    for (int l = 0; l < 10; l++) begin
      for (int i = 0; i < 100; i++) pix(8'd60, -1, 8'h00, "");
      idle(4);
    end
    c_auto = 1; c_off = 8'd10;
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0); t0 = cyc;
    lit(t0 + 9, 2, 8'h00, "auto_vld_early");
    lit(t0 + 10, 2, 8'h01, "auto_vld");
    lit(t0 + 10, 1, 8'd60, "auto_mean");
    lit(t0 + 11, 2, 8'h00, "auto_vld_late");
    vsync(1); idle(14);
    pix(8'd70, 0, 8'hFF, "auto_70"); pix(8'd69, 0, 8'h00, "auto_69");
    idle(3);

    // Saturation high: mean 250, offset +20
    vsync(2); idle(5);
    for (int i = 0; i < 200; i++) pix(8'd250, -1, 8'h00, "");
    idle(3); c_off = 8'd20;
    vsync(2); idle(14);
    pix(8'd254, 0, 8'h00, "sat_hi_254"); pix(8'd255, 0, 8'hFF, "sat_hi_255");
    idle(3);

    // Saturation low: mean 5, offset -20
    vsync(2); idle(5);
    for (int i = 0; i < 100; i++) pix(8'd5, -1, 8'h00, "");
    idle(3); c_off = 8'hEC;
    vsync(2); idle(14);
    pix(8'd0, 0, 8'hFF, "sat_lo_0"); pix(8'd3, 0, 8'hFF, "sat_lo_3");
    idle(3);

    // Empty frame: previous frame mean is (0+3)/2 = 1
    vsync(2); idle(20);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0); t0 = cyc;
    lit(t0 + 10, 2, 8'h00, "empty_vld");
    lit(t0 + 10, 1, 8'd1, "empty_mean");
    vsync(1); idle(15);
    c_auto = 0;

    // Reset in the middle of a division
    for (int i = 0; i < 50; i++) pix(8'd123, -1, 8'h00, "");
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0); t0 = cyc;
    vsync(1); idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    lit(t0 + 10, 2, 8'h00, "rstdiv_vld");
    lit(t0 + 10, 1, 8'h80, "rstdiv_mean");
    idle(12);
    vsync(2); idle(5);
    for (int i = 0; i < 100; i++) pix(8'd77, -1, 8'h00, "");
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'd0); t0 = cyc;
    lit(t0 + 10, 1, 8'd77, "post_rst_mean");
    lit(t0 + 10, 2, 8'h01, "post_rst_vld");
    vsync(1); idle(15);

    // Random frames checked by the model
    for (int f = 0; f < 8; f++) begin
      c_auto = 1'($urandom); c_thr = 8'($urandom); c_off = 8'($urandom);
      c_hyst = 4'($urandom);
      vsync(1 + $urandom_range(2)); idle(12 + $urandom_range(8));
      nl = 3 + $urandom_range(3);
      for (int l = 0; l < nl; l++) begin
        c_inv = 1'($urandom);
        len = 5 + $urandom_range(35);
        for (int i = 0; i < len; i++) begin
          v = ($urandom_range(3) == 0) ? int'($urandom_range(255))
                                       : int'(c_thr) + int'($urandom_range(24)) - 12;
          if (v < 0) v = 0;
          if (v > 255) v = 255;
          pix(8'(v), -1, 8'h00, "");
        end
        if (f == 4 && l == 1) step(1'b1, 1'b1, 1'b0, 1'b0, 8'd9);
        idle(2 + $urandom_range(4));
      end
    end
    idle(15);

    foreach (lits[i]) begin
      n_chk++; n_err++;
      $display("FAIL %s: expectation at cycle %0d never reached", lits[i].nm, lits[i].at);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/luma_key.md
# luma_key

Luma keyer that sits directly downstream of the RGB-to-luma converter and consumes its 8-bit luma stream. It produces a hard key mask (0x00/0xFF) with line-local hysteresis. Its threshold is either manual or derived automatically from the previous frame's mean luma, which a small iterative divider computes during vertical blanking. Sync and data-enable are delayed to stay aligned with the key output.

## Interface
- SYNC_POL, 1: asserted level of the HSync/VSync inputs (1 = active-high).
- clk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- vid_pData_in  in  8  luma from the converter stage
- vid_pVDE_in / vid_pHSync_in / vid_pVSync_in  in  1  data enable and syncs
- auto_en  in  1  1 = auto threshold (mean + offset), 0 = manual threshold
- thresh_in  in  8  manual threshold
- offset_in  in  8  signed offset added to the mean in auto mode
- hyst_in  in  4  hysteresis width
- invert  in  1  invert the key
- vid_pData_out  out  8  key mask, 0x00 or 0xFF
- vid_pVDE_out / vid_pHSync_out / vid_pVSync_out  out  1  inputs delayed by 2 cycles
- mean_out  out  8  last computed frame mean
- mean_valid  out  1  one-cycle pulse when mean_out updates

## Operation
- **Accumulator**
  - sum (32 b) += luma and count (22 b) += 1 on every cycle with vid_pVDE_in = 1.
- **Frame edge**
  - Detected in stage 1 as VSync going from deasserted to asserted.
  - On that cycle, sum and count are snapshotted into the divider and the accumulators clear.
  - A DE pixel in the same cycle as the edge goes into the new frame.
- **Divider FSM** (IDLE -> DIV -> DONE -> IDLE)
  - DIV: restoring division, 8 iterations, quotient bit k = 7..0. Each iteration compares the remainder against count<<k.
  - The quotient is at most 255 by construction.
  - DONE: writes mean_out and pulses mean_valid.
  - count = 0 at the snapshot: stays in IDLE, mean_out is held, no pulse.
  - A new frame edge while in DIV aborts the division and restarts it with the new snapshot.
- **Threshold latch**
  - An arm flag sets on the frame edge.
  - On the first DE-rising after arming, the active threshold thr latches and the flag clears.
  - Auto mode: thr = sat(mean_out + sign-extended offset_in) over the range 0..255.
  - Manual mode: thr = thresh_in.
  - thr is constant for the whole frame. If the divider is still busy at the latch, the previous mean_out is used.
- **Key decision**
  - thr_lo = thr - hyst_in, saturating at 0.
  - key_state = 0: key = (luma >= thr). key_state = 1: key = (luma >= thr_lo).
  - key_state follows key on active pixels and clears whenever DE = 0, so hysteresis is line-local.
  - thr = 0 gives the key always on.
- **Output**
  - DE = 1: vid_pData_out = 0xFF when key XOR invert is 1, else 0x00.
  - DE = 0: vid_pData_out = 0x00 regardless of invert.
- **Reset** (synchronous, any cycle including mid-division)
  - All pipeline registers, outputs, accumulators and key_state go to 0.
  - FSM returns to IDLE; the arm flag clears.
  - mean_out = 0x80, thr = 0x80, mean_valid = 0.

## Timing
- Pixel path latency is exactly 2 cycles:
  - Stage 1 registers luma, DE, syncs and the edge flags.
  - Stage 2 computes the key and registers all video outputs.
- Frame edge with VSync asserted at the input in cycle T:
  - Snapshot at T+1.
  - DIV iterations at T+2..T+9.
  - DONE at T+10: mean_out valid, mean_valid = 1 for that cycle only.
- The divider needs 10 cycles per frame, well inside any vertical blanking interval.
- Throughput is one pixel per clock with no stalls and no backpressure.

## Structure
- Package luma_key_pkg holds:
  - SUM_W = 32, CNT_W = 22
  - the FSM state enum (IDLE, DIV, DONE)
  - MEAN_RST = 8'h80
- Sub-module luma_mean_div holds the snapshot registers, the 8-iteration restoring divider FSM, mean_out and mean_valid.
- Top level holds the accumulators, edge detection, threshold latch, hysteresis and the 2-stage pipeline.

## Test plan
- **Reset:** assert rst for 3 cycles while driving DE/syncs.
  - Outputs are 0 and mean_out = 0x80, with mean_valid = 0 throughout.
  - One cycle after release, outputs follow the delayed inputs.
- **Manual, no hysteresis:** thresh 100, hyst 0, DE luma 98,99,100,101.
  - Output 00,00,FF,FF two cycles later, with syncs and DE delayed by exactly 2.
  - With invert = 1 the output is FF,FF,00,00; with DE = 0 the output stays 00.
- **Hysteresis:** thresh 100, hyst 8, DE luma 105,95,92,91,95,105.
  - Output FF,FF,FF,00,00,FF.
  - After a DE gap, a next line starting with 95 gives 00.
- **Auto mean:** frame of 1000 pixels at luma 60, then VSync edge at T.
  - mean_out = 60 and mean_valid pulses at T+10.
  - Next frame with offset +10, auto_en: luma 70 -> FF, 69 -> 00.
  - mean 250 with offset +20 latches thr = 255; mean 5 with offset -20 latches thr = 0.
- **Empty frame:** two VSync edges with no DE between them.
  - mean_out is unchanged and mean_valid stays 0.
- **Reset mid-division:** rst at T+5.
  - FSM returns to IDLE, no mean_valid pulse, mean_out = 0x80.
  - The following frame computes its mean correctly.
